periph_csb_bridge_q: RTL

Pipelined, parametrised bridge from the HWPE peripheral slave port to the NVDLA CSB register interface.
- Accepts up to OUTSTANDING requests in flight.
- Tracks each request's ID and kind in an in-order queue.
- Buffers CSB read data and write completions, and returns responses in request order on the periph r channel.
- Decodes an address window, rejects partial-byte writes, and selects posted or non-posted writes.
- Sits between the cluster peripheral interconnect and the nvdla top in the accelerator wrapper.

---
 rtl/periph_csb_bridge_q.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/periph_csb_bridge_q.sv
// HWPE peripheral slave to NVDLA CSB bridge with an in-order ID queue and a
// response buffer, so that several CSB accesses can be in flight at once.
module periph_csb_bridge_q #(
    parameter int unsigned ID_WIDTH     = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [31:0] WINDOW_BYTES = 32'h0004_0000,
    parameter int unsigned OUTSTANDING  = 4,
    parameter bit          NPOSTED      = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         periph_req_i,
    input  logic [31:0]                  periph_add_i,
    input  logic                         periph_wen_i,
    input  logic [3:0]                   periph_be_i,
    input  logic [31:0]                  periph_data_i,
    input  logic [ID_WIDTH-1:0]          periph_id_i,
    output logic                         periph_gnt_o,
    output logic [31:0]                  periph_r_data_o,
    output logic                         periph_r_valid_o,
    output logic [ID_WIDTH-1:0]          periph_r_id_o,
    output logic                         csb2nvdla_valid,
    input  logic                         csb2nvdla_ready,
    output logic [15:0]                  csb2nvdla_addr,
    output logic [31:0]                  csb2nvdla_wdat,
    output logic                         csb2nvdla_write,
    output logic                         csb2nvdla_nposted,
    input  logic                         nvdla2csb_valid,
    input  logic [31:0]                  nvdla2csb_data,
    input  logic                         nvdla2csb_wr_complete,
    output logic [$clog2(OUTSTANDING):0] outstanding_o,
    output logic                         err_o
);

    localparam int unsigned AW = $clog2(OUTSTANDING);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        K_READ = 2'd0,
        K_NPW  = 2'd1,
        K_PW   = 2'd2,
        K_ERR  = 2'd3
    } kind_e;

    logic [ID_WIDTH-1:0] q_id_r   [OUTSTANDING];
    kind_e               q_kind_r [OUTSTANDING];
    logic [CW-1:0]       q_wp_r, q_rp_r, q_cnt_r;
    logic [31:0]         rb_mem_r [OUTSTANDING];
    logic [CW-1:0]       rb_wp_r, rb_rp_r;
    logic [CW-1:0]       exp_cnt_r;

    logic                csb_valid_r, csb_write_r, csb_nposted_r;
    logic [15:0]         csb_addr_r;
    logic [31:0]         csb_wdat_r;
    logic                r_valid_r, err_r;
    logic [31:0]         r_data_r;
    logic [ID_WIDTH-1:0] r_id_r;

    logic [31:0]         off_s;
    logic                in_win_s;
    kind_e               kind_s, head_kind_s;
    logic [ID_WIDTH-1:0] head_id_s;
    logic                q_full_s, q_empty_s, rb_empty_s;
    logic                gnt_s, pop_s, rb_pop_s, exp_inc_s;
    logic [31:0]         pop_data_s;
    logic                acc_rd_s, acc_wc_s, drop_s;
    logic [CW-1:0]       rb_wp1_s;
    logic [AW-1:0]       wc_idx_s;

    // Request classification against the CSB window and byte-enable rules.
    always_comb begin
        off_s    = periph_add_i - BASE_ADDR;
        in_win_s = (periph_add_i >= BASE_ADDR) && (off_s < WINDOW_BYTES);
        kind_s   = K_ERR;
        if (!in_win_s) begin
            kind_s = K_ERR;
        end else if (periph_wen_i) begin
            kind_s = K_READ;
        end else if (periph_be_i != 4'hF) begin
            kind_s = K_ERR;
        end else if (NPOSTED) begin
            kind_s = K_NPW;
        end else begin
            kind_s = K_PW;
        end
    end

    // Queue status, grant and acceptance of CSB responses.
    always_comb begin
        q_empty_s  = (q_wp_r == q_rp_r);
        q_full_s   = (q_wp_r[AW] != q_rp_r[AW]) && (q_wp_r[AW-1:0] == q_rp_r[AW-1:0]);
        rb_empty_s = (rb_wp_r == rb_rp_r);
        gnt_s      = periph_req_i && !q_full_s && (!csb_valid_r || csb2nvdla_ready);
        exp_inc_s  = gnt_s && ((kind_s == K_READ) || (kind_s == K_NPW));
        // Only responses that some queued READ/NPW still owes are buffered.
        acc_rd_s   = nvdla2csb_valid && (exp_cnt_r != {CW{1'b0}});
        acc_wc_s   = nvdla2csb_wr_complete && ((exp_cnt_r - CW'(acc_rd_s)) != {CW{1'b0}});
        drop_s     = (nvdla2csb_valid && !acc_rd_s) || (nvdla2csb_wr_complete && !acc_wc_s);
        rb_wp1_s   = rb_wp_r + {{AW{1'b0}}, 1'b1};
        wc_idx_s   = acc_rd_s ? rb_wp1_s[AW-1:0] : rb_wp_r[AW-1:0];
    end

    // Head-of-queue pop decision; write responses carry no data.
    always_comb begin
        head_kind_s = q_kind_r[q_rp_r[AW-1:0]];
        head_id_s   = q_id_r[q_rp_r[AW-1:0]];
        pop_s       = 1'b0;
        rb_pop_s    = 1'b0;
        pop_data_s  = 32'h0000_0000;
        if (!q_empty_s) begin
            case (head_kind_s)
                K_PW: begin
                    pop_s = 1'b1;
                end
                K_ERR: begin
                    pop_s      = 1'b1;
                    pop_data_s = 32'hDEAD_BEEF;
                end
                K_READ: begin
                    if (!rb_empty_s) begin
                        pop_s      = 1'b1;
                        rb_pop_s   = 1'b1;
                        pop_data_s = rb_mem_r[rb_rp_r[AW-1:0]];
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                K_NPW: begin
                    if (!rb_empty_s) begin
                        pop_s    = 1'b1;
                        rb_pop_s = 1'b1;
                    end else begin
                        pop_s = 1'b0;
                    end
                end
                default: begin
                    pop_s = 1'b0;
                end
            endcase
        end else begin
            pop_s = 1'b0;
        end
    end

    // Storage arrays; their contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (gnt_s) begin
            q_id_r[q_wp_r[AW-1:0]]   <= periph_id_i;
            q_kind_r[q_wp_r[AW-1:0]] <= kind_s;
        end
        if (acc_rd_s) begin
            rb_mem_r[rb_wp_r[AW-1:0]] <= nvdla2csb_data;
        end
        if (acc_wc_s) begin
            rb_mem_r[wc_idx_s] <= 32'h0000_0000;
        end
    end

    // Pointers, counters, CSB request register and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wp_r        <= {CW{1'b0}};
            q_rp_r        <= {CW{1'b0}};
            q_cnt_r       <= {CW{1'b0}};
            rb_wp_r       <= {CW{1'b0}};
            rb_rp_r       <= {CW{1'b0}};
            exp_cnt_r     <= {CW{1'b0}};
            csb_valid_r   <= 1'b0;
            csb_write_r   <= 1'b0;
            csb_nposted_r <= 1'b0;
            csb_addr_r    <= 16'h0000;
            csb_wdat_r    <= 32'h0000_0000;
            r_valid_r     <= 1'b0;
            r_data_r      <= 32'h0000_0000;
            r_id_r        <= {ID_WIDTH{1'b0}};
            err_r         <= 1'b0;
        end else begin
            q_wp_r    <= q_wp_r + CW'(gnt_s);
            q_rp_r    <= q_rp_r + CW'(pop_s);
            q_cnt_r   <= q_cnt_r + CW'(gnt_s) - CW'(pop_s);
            rb_wp_r   <= rb_wp_r + CW'(acc_rd_s) + CW'(acc_wc_s);
            rb_rp_r   <= rb_rp_r + CW'(rb_pop_s);
            exp_cnt_r <= exp_cnt_r + CW'(exp_inc_s) - CW'(acc_rd_s) - CW'(acc_wc_s);
            if (gnt_s && (kind_s != K_ERR)) begin
                csb_valid_r   <= 1'b1;
                csb_addr_r    <= off_s[17:2];
                csb_wdat_r    <= periph_data_i;
                csb_write_r   <= !periph_wen_i;
                csb_nposted_r <= !periph_wen_i && NPOSTED;
            end else if (csb2nvdla_ready) begin
                csb_valid_r <= 1'b0;
            end
            r_valid_r <= pop_s;
            r_data_r  <= pop_s ? pop_data_s : 32'h0000_0000;
            r_id_r    <= pop_s ? head_id_s : {ID_WIDTH{1'b0}};
            if (drop_s || (pop_s && (head_kind_s == K_ERR))) begin
                err_r <= 1'b1;
            end
        end
    end

    assign periph_gnt_o      = gnt_s;
    assign periph_r_valid_o  = r_valid_r;
    assign periph_r_data_o   = r_data_r;
    assign periph_r_id_o     = r_id_r;
    assign csb2nvdla_valid   = csb_valid_r;
    assign csb2nvdla_addr    = csb_addr_r;
    assign csb2nvdla_wdat    = csb_wdat_r;
    assign csb2nvdla_write   = csb_write_r;
    assign csb2nvdla_nposted = csb_nposted_r;
    assign outstanding_o     = q_cnt_r;
    assign err_o             = err_r;

endmodule
